// File: rtl/seq_pkg.sv
// Constants shared by the 1011 framer and the matching overlapping Mealy detector.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_PAT = 4'b1011;
  localparam int         SYNC_LEN = 4;

  // A line history equal to the sync prefix means the next bit could complete a false sync.
  localparam logic [2:0] STUFF_PAT = SYNC_PAT[3:1];

endpackage

// File: rtl/seq_stuff_ctrl.sv
// Line-history tracker for bit stuffing: flags when the next line bit must be a stuff 0.
module seq_stuff_ctrl
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic clear,
  input  logic line_bit,
  input  logic next_bit,
  output logic stuff_now,
  output logic stuff_after
);

  logic [2:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 3'b000;
    end else if (clear) begin
      hist <= 3'b000;
    end else if (shift) begin
      hist <= {hist[1:0], line_bit};
    end
  end

  assign stuff_now   = (hist == STUFF_PAT);
  // Lookahead: would emitting next_bit leave the history needing a stuff bit?
  assign stuff_after = ({hist[1:0], next_bit} == STUFF_PAT);

endmodule

// File: rtl/seq_1011_framer.sv
// Serial framer: sync word 1011 then payload MSB-first over a valid/ready input.
// Optional bit stuffing is enabled by defining SEQ_FRAMER_STUFF_EN.
module seq_1011_framer
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              x_out,
  output logic              busy,
  output logic              sync_bit,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where data_valid && data_ready;
  // data_ready never depends on data_valid, and data_in is sampled only on that edge.

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);

  state_t            state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [CW-1:0]     dcnt, dcnt_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic              accept, last_bit, pay_bit;
  logic              stuff_now, stuff_after;

  assign pay_bit = sreg[DATA_W-1];

`ifdef SEQ_FRAMER_STUFF_EN
  seq_stuff_ctrl u_stuff (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift      (busy),
    .clear      (state_nx == IDLE),
    .line_bit   (x_out),
    .next_bit   (pay_bit),
    .stuff_now  (stuff_now),
    .stuff_after(stuff_after)
  );
`else
  assign stuff_now   = 1'b0;
  assign stuff_after = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      dcnt  <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dcnt  <= dcnt_nx;
      sreg  <= sreg_nx;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    x_out    = 1'b0;
    last_bit = 1'b0;
    unique case (state)
      IDLE: ;
      SYNC: x_out = SYNC_PAT[2'd3 - cnt];
      DATA: begin
        if (dcnt == FULL_CNT) begin
          last_bit = 1'b1;  // trailing stuff 0 after the final payload bit
        end else if (!stuff_now) begin
          x_out    = pay_bit;
          last_bit = (dcnt == LAST_IDX) && !stuff_after;
        end
      end
      default: ;
    endcase
  end

  assign data_ready = (state == IDLE) || last_bit;
  assign accept     = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign sync_bit   = (state == SYNC);
  assign frame_done = last_bit;
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dcnt_nx  = dcnt;
    sreg_nx  = sreg;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SYNC;
          cnt_nx   = 2'd0;
          sreg_nx  = data_in;
        end
      end
      SYNC: begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'(SYNC_LEN - 1)) begin
          state_nx = DATA;
          dcnt_nx  = '0;
        end
      end
      DATA: begin
        if (dcnt != FULL_CNT && !stuff_now) begin
          sreg_nx = sreg << 1;
          dcnt_nx = dcnt + CW'(1);
        end
        if (last_bit) begin
          if (accept) begin
            state_nx = SYNC;
            cnt_nx   = 2'd0;
            sreg_nx  = data_in;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_1011_framer.sv
// Bench for seq_1011_framer: frame-level reference model feeding an expected-bit queue.
module tb_seq_1011_framer;

  localparam int DATA_W = 8;
`ifdef SEQ_FRAMER_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready, x_out, busy, sync_bit, frame_done;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  // Each entry is one expected line cycle: {x_out, sync_bit, frame_done}.
  logic [2:0]  exp_q[$];
  logic [2:0]  mhist = 3'b000;
  logic [3:0]  sync_word = 4'b1011;
  logic [3:0]  win = 4'b0000;
  logic [63:0] line_log = '0;
  int          log_len = 0;

  logic [2:0]  mon_cur;
  logic        mon_have, mon_ready;

  seq_1011_framer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .x_out     (x_out),
    .busy      (busy),
    .sync_bit  (sync_bit),
    .frame_done(frame_done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Builds a whole frame from the line rules: sync word, payload MSB-first, and a 0
  // inserted whenever the last three line bits are 101 (stuffing builds only).
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [2:0] h;
    logic [2:0] ent[$];
    logic [2:0] last;
    logic       b;
    h = mhist;
    for (int i = 0; i < 4; i++) begin
      b = sync_word[3-i];
      ent.push_back({b, 2'b10});
      h = {h[1:0], b};
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (STUFF && h == 3'b101) begin
        ent.push_back(3'b000);
        h = {h[1:0], 1'b0};
      end
      b = d[i];
      ent.push_back({b, 2'b00});
      h = {h[1:0], b};
    end
    if (STUFF && h == 3'b101) ent.push_back(3'b000);
    last = ent.pop_back();
    last[0] = 1'b1;
    ent.push_back(last);
    foreach (ent[k]) exp_q.push_back(ent[k]);
  endtask

  function automatic int count_1011(input logic [63:0] v, input int len);
    int c = 0;
    for (int i = 0; i + 3 < len; i++) if (v[i+:4] == 4'b1011) c++;
    return c;
  endfunction

  // Monitor: one expected entry per line cycle, idle when the queue is empty.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_have  = (exp_q.size() > 0);
      mon_cur   = mon_have ? exp_q.pop_front() : 3'b000;
      mon_ready = !mon_have || mon_cur[0];
      check("x_out",      32'(x_out),      32'(mon_cur[2]));
      check("sync_bit",   32'(sync_bit),   32'(mon_cur[1]));
      check("frame_done", 32'(frame_done), 32'(mon_cur[0]));
      check("busy",       32'(busy),       32'(mon_have));
      check("data_ready", 32'(data_ready), 32'(mon_ready));
      win   = {win[2:0], x_out};
`ifdef SEQ_FRAMER_STUFF_EN
      if (win == 4'b1011) check("1011_outside_sync", 32'(sync_bit), 32'd1);
`endif
      mhist = mon_have ? {mhist[1:0], mon_cur[2]} : 3'b000;
      if (mon_have) begin
        line_log = {line_log[62:0], x_out};
        log_len++;
      end
      if (mon_ready && data_valid === 1'b1) begin
        push_frame(data_in);
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input bit keep_valid);
    int a0;
    int n;
    data_in    = d;
    data_valid = 1'b1;
    a0 = acc_cnt;
    n  = 0;
    while (acc_cnt == a0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("accept_within_budget", 32'(n < 300), 32'd1);
    #1;
    if (!keep_valid) data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_within_budget", 32'(n < 300), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    line_log = '0;
    log_len  = 0;
  endtask

  task automatic check_line(input string name, input logic [31:0] exp_bits, input int exp_len,
                            input int exp_syncs);
    check({name, "_bits"},  line_log[31:0], exp_bits);
    check({name, "_len"},   32'(log_len),   32'(exp_len));
    check({name, "_syncs"}, 32'(count_1011(line_log, log_len)), 32'(exp_syncs));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_x_out",      32'(x_out),      32'd0);
    check("rst_data_ready", 32'(data_ready), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sync_bit",   32'(sync_bit),   32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single A5 frame.
    clear_log();
    send(8'hA5, 1'b0);
    wait_idle();
    if (STUFF) check_line("a5", 32'h2E8A, 14, 1);
    else       check_line("a5", 32'h0BA5, 12, 1);

    // Back-to-back FF then 00 with valid held high.
    clear_log();
    send(8'hFF, 1'b1);
    send(8'h00, 1'b0);
    wait_idle();
    check_line("b2b", 32'h00BF_FB00, 24, 2);

    // Valid pulsed with new data during payload bit 3 must be ignored.
    clear_log();
    send(8'h3C, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    data_in    = 8'hC3;
    data_valid = 1'b1;
    check("ignored_valid_ready", 32'(data_ready), 32'd0);
    @(posedge clk);
    #1 data_valid = 1'b0;
    wait_idle();
    check_line("ignored", 32'h0B3C, 12, 1);

    // Reset during payload bit 3 abandons the frame immediately.
    send(8'h96, 1'b0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    mhist = 3'b000;
    win   = 4'b0000;
    #1;
    check("midrst_x_out",      32'(x_out),      32'd0);
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_data_ready", 32'(data_ready), 32'd1);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send(8'hC3, 1'b0);
    wait_idle();
    check_line("after_rst", 32'h0BC3, 12, 1);

    // Random valid/data traffic: gaps, back-to-back frames and ignored offers.
    for (int c = 0; c < 600; c++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      data_in    = DATA_W'($urandom);
      @(posedge clk);
      #1;
    end
    data_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_1011_framer.md
# seq_1011_framer

Serial frame transmitter that pairs with the overlapping `1011` Mealy sequence detector. It accepts a parallel payload word over a valid/ready handshake and emits one bit per clock on `x_out`: first the sync word `1011`, then the payload MSB-first. A detector on the far end fires exactly once per frame, on the last sync bit. Optional bit stuffing keeps the `1011` pattern from ever appearing outside the sync word.

## Interface
- `DATA_W`, default 8: payload width in bits; minimum 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  DATA_W: payload word; sampled only on an accept edge.
- `data_valid`  in  1: payload offered.
- `data_ready`  out  1: framer can accept. Accept edge = rising edge with `data_valid && data_ready`.
- `x_out`  out  1: serial line; 0 when idle.
- `busy`  out  1: high while a frame is on the line (SYNC or DATA).
- `sync_bit`  out  1: high while `x_out` carries a sync bit.
- `frame_done`  out  1: high during the final bit cycle of a frame.

## Operation
- States:
  - IDLE: line is 0, `data_ready`=1.
  - SYNC: 4 bits, `cnt` runs 0..3, `x_out` = SYNC_PAT[3-cnt].
  - DATA: payload bits MSB-first from a shift register, plus stuff bits when enabled.
- Transitions:
  - IDLE to SYNC on an accept edge. The payload is latched and `cnt` is cleared.
  - SYNC to DATA after `cnt`=3.
  - DATA to IDLE after the final bit, or DATA to SYNC if an accept happens on that same edge (back-to-back frames, no gap).
- `data_ready` is 1 in IDLE and during the final bit cycle of DATA. It is 0 otherwise.
- `data_valid` seen while `data_ready`=0 is ignored. `data_in` is never re-sampled mid-frame.
- All outputs are decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset values: state IDLE, `x_out`=0, `data_ready`=1, `busy`=0, `sync_bit`=0, `frame_done`=0, history=000.
- Reset asserted mid-frame: outputs go immediately to reset values and the frame is abandoned. The next frame starts with a full sync word.
- History register `hist[2:0]` holds the last three line bits. It shifts on every edge where a bit is emitted and is cleared to 000 in IDLE, since the idle line is 0.

## Timing
- Accept at edge E: the first sync bit (1) is on `x_out` in the cycle after E.
- Sync bits occupy cycles E+1..E+4. Payload bits occupy E+5..E+4+DATA_W when there is no stuffing.
- Frame length is 4+DATA_W cycles without stuffing, or 4+DATA_W+S cycles with S stuff bits.
- `frame_done` and `data_ready` are both high in the final cycle. An accept on that cycle's closing edge puts the next sync bit out in the following cycle.
- `sync_bit`=1 exactly in cycles E+1..E+4.

## Configuration
- `SEQ_FRAMER_STUFF_EN` defined:
  - In DATA, whenever `hist`==101, emit a 0 stuff bit before the next payload bit. The payload pointer does not advance for a stuff bit.
  - After the last payload bit, if `hist`==101, emit one trailing stuff 0. That stuff bit is then the final bit cycle.
  - Result: `1011` appears on the line only as the sync word, including across back-to-back frames.
- `SEQ_FRAMER_STUFF_EN` undefined: no stuffing and fixed frame length. `hist` logic is removed. Payload may alias the sync word.

## Structure
- Shared package `seq_pkg`:
  - State enum (IDLE, SYNC, DATA).
  - `SYNC_PAT` = 4'b1011 and `SYNC_LEN` = 4. The detector imports the same constants.
- One sub-module, `seq_stuff_ctrl`: holds `hist` and produces the `stuff_now` flag. It is instantiated only under `SEQ_FRAMER_STUFF_EN`.
- Top level holds the FSM, the bit counter, the shift register and the handshake logic.

## Test plan
All scenarios use DATA_W=8.
- **Reset:** with `rst_n`=0, `x_out`=0, `data_ready`=1, `busy`=0, `frame_done`=0. The same values hold after release with no valid.
- **Single frame, macro off:** `data_in`=8'hA5 accepted → line carries 1011_10100101 over 12 cycles. `sync_bit` is high for cycles 1-4 and `frame_done` is high in cycle 12. The line then returns to 0.
- **Single frame, macro on:** `data_in`=8'hA5 → line carries 1011_1010_0010_10, 14 bits, with stuff bits at positions 8 and 14. A looped-back detector pulses `z` exactly once, at bit 4.
- **Back-to-back, macro off:** hold `data_valid` with 8'hFF then 8'h00 → 24 contiguous bits 1011_11111111_1011_00000000. `data_ready` is high only in cycles 12 and 24.
- **Ignored valid:** change `data_in` and pulse `data_valid` during payload bit 3 → the frame is unchanged and `data_ready` stays 0.
- **Mid-frame reset:** assert `rst_n`=0 during payload bit 3 → `x_out`=0 and `busy`=0 without waiting for a clock. The next accept sends a full 1011 sync before its payload.
